vrf_seq: RTL and testbench
==========================

Name: vrf_seq

Overview:
Next-generation vector register file with an integrated read sequencer and a register scoreboard. It holds els_p vectors of vlen_p elements, interleaved across lanes_p lanes: element e lives in lane e mod lanes_p, beat e/lanes_p. An accepted issue streams up to rports_p source vectors beat by beat to the lane datapaths. Lane write-back lands asynchronously through a separate write port, and the scoreboard blocks RAW and WAW hazards.

Parameters:
els_p, 32, number of vector registers
vlen_p, 8, elements per vector (multiple of lanes_p)
vdw_p, 32, bits per element
lanes_p, 4, lanes; beats_lp = vlen_p/lanes_p
rports_p, 3, source vectors read per issue

Ports:
clk_i  in  1  clock
reset_n_i  in  1  async active-low reset
issue_v_i  in  1  issue request valid
issue_ready_o  out  1  issue accepted when issue_v_i & issue_ready_o
issue_rs_addr_i  in  rports_p*clog2(els_p)  source register per read port
issue_rs_en_i  in  rports_p  source port used (unused ports skip hazard check)
issue_rd_addr_i  in  clog2(els_p)  destination register
issue_wb_i  in  1  op writes rd (marks rd busy)
issue_vl_i  in  clog2(vlen_p+1)  active vector length, 0..vlen_p
r_v_o  out  1  read beat valid
r_ready_i  in  1  lanes accept beat
r_data_o  out  rports_p*lanes_p*vdw_p  source elements of current beat
r_mask_o  out  lanes_p  lane l active iff beat*lanes_p+l < vl
r_last_o  out  1  final beat of op
w_v_i  in  1  write-back valid (always accepted)
w_reg_addr_i  in  clog2(els_p)  target register
w_beat_i  in  clog2(beats_lp)  target beat
w_data_i  in  lanes_p*vdw_p  per-lane data
w_mask_i  in  lanes_p  per-lane write enable
w_last_i  in  1  final write of op; clears busy[w_reg_addr_i]
busy_o  out  els_p  scoreboard state

Behaviour:
- Reset (async, reset_n_i=0): FSM to IDLE, beat counter 0, busy_o=0, r_v_o=0, r_last_o=0, storage cleared to 0. Reset mid-stream abandons the op; no further beats.
- FSM states:
  - IDLE: issue_ready_o=1 iff no enabled rs is busy and (issue_wb_i=0 or rd not busy). Hazard check uses registered busy only.
  - On accept with vl>0: latch rs addrs, vl and nbeats=ceil(vl/lanes_p); go to STREAM, beat=0. If issue_wb_i, set busy[rd] next cycle.
  - On accept with vl=0: stay IDLE, emit no beats, do not set busy.
  - STREAM: issue_ready_o=0, r_v_o=1. Beat advances on r_v_o&r_ready_i. r_last_o=1 when beat==nbeats-1; its handshake returns FSM to IDLE.
- Latency: accept in cycle N puts the first beat valid in N+1.
- Backpressure: while r_ready_i=0, r_data_o, r_mask_o and r_last_o hold stable.
- r_data_o is combinational from storage at the latched rs and current beat. Masked lanes carry stored data; consumers ignore them.
- Writes: at posedge, storage[w_reg][w_beat][l] is written for each l with w_mask_i[l]. Writes are independent of FSM state, and masked-off lanes are unchanged.
- Same-cycle read and write of the same element: read returns the old value; the new value is visible next cycle (unless VRF_WBYPASS_EN).
- Scoreboard:
  - set on accept with wb; clear on w_v_i&w_last_i for that register.
  - Set and clear of the same register in the same cycle: set wins.
  - Clear of a non-busy register: no effect.
- One op in flight in the sequencer. Outstanding write-backs to multiple registers are allowed.

Optional Feature:
VRF_WBYPASS_EN
- Defined: in any r_data_o lane whose register, beat and lane match an active write (w_v_i & w_mask_i[l]), w_data_i is forwarded combinationally in the same cycle. This applies to every read port.
- Undefined: no forwarding; reads see pre-write storage. Port list is identical in both builds.

Test Plan:
- Reset, write v5 beat0 lanes {1,2,3,4} and beat1 {5,6,7,8}; issue rs0=5, vl=8 -> 2 beats, first in N+1: data {1,2,3,4} then {5,6,7,8}, r_mask_o=4'b1111, r_last_o on beat 1.
- vl=6 on v5 -> 2 beats; beat1 r_mask_o=4'b0011; vl=0 -> no r_v_o, issue_ready_o stays 1, busy_o unchanged.
- Issue wb rd=3, vl=8 -> busy_o[3]=1. Next issue reading rs0=3 -> issue_ready_o=0 until w_v_i&w_last_i to v3, then accepted the cycle after the clear.
- Hold r_ready_i=0 for 3 cycles mid-stream -> beat data, mask and last held constant; completion is delayed by exactly 3 cycles.
- Write v5 beat0 lane2 = 0xDEAD while streaming that beat -> old value without VRF_WBYPASS_EN, 0xDEAD same cycle with it.
- Assert reset_n_i during STREAM of a 2-beat op -> r_v_o=0 immediately, busy_o=0, storage 0, issue_ready_o=1 after release.

Source files
------------

// File: rtl/vrf_seq.sv
// Vector register file with an issue-driven beat read sequencer and a busy scoreboard.
// Define VRF_WBYPASS_EN to forward same-cycle write-back data onto r_data_o.
module vrf_seq #(
  parameter int els_p    = 32,
  parameter int vlen_p   = 8,
  parameter int vdw_p    = 32,
  parameter int lanes_p  = 4,
  parameter int rports_p = 3,
  localparam int aw_lp    = $clog2(els_p),
  localparam int vlw_lp   = $clog2(vlen_p + 1),
  localparam int beats_lp = vlen_p / lanes_p,
  localparam int bw_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               issue_v_i,
  output logic                               issue_ready_o,
  input  logic [rports_p*aw_lp-1:0]          issue_rs_addr_i,
  input  logic [rports_p-1:0]                issue_rs_en_i,
  input  logic [aw_lp-1:0]                   issue_rd_addr_i,
  input  logic                               issue_wb_i,
  input  logic [vlw_lp-1:0]                  issue_vl_i,
  output logic                               r_v_o,
  input  logic                               r_ready_i,
  output logic [rports_p*lanes_p*vdw_p-1:0]  r_data_o,
  output logic [lanes_p-1:0]                 r_mask_o,
  output logic                               r_last_o,
  input  logic                               w_v_i,
  input  logic [aw_lp-1:0]                   w_reg_addr_i,
  input  logic [bw_lp-1:0]                   w_beat_i,
  input  logic [lanes_p*vdw_p-1:0]           w_data_i,
  input  logic [lanes_p-1:0]                 w_mask_i,
  input  logic                               w_last_i,
  output logic [els_p-1:0]                   busy_o
);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e state_q, state_d;

  logic [vdw_p-1:0] mem [els_p][beats_lp][lanes_p];

  logic [rports_p*aw_lp-1:0] rs_q;
  logic [vlw_lp-1:0]         vl_q;
  logic [bw_lp-1:0]          last_q;
  logic [bw_lp-1:0]          beat_q, beat_d;
  logic [els_p-1:0]          busy_q, busy_d;

  logic hazard;
  logic accept;
  logic vl_nz;

  assign vl_nz  = |issue_vl_i;
  assign accept = issue_v_i & issue_ready_o;
  assign busy_o = busy_q;

  // Hazard check looks only at registered busy, never at same-cycle clears.
  always_comb begin
    hazard = issue_wb_i & busy_q[issue_rd_addr_i];
    for (int p = 0; p < rports_p; p++) begin
      if (issue_rs_en_i[p] &&
          busy_q[issue_rs_addr_i[p*aw_lp +: aw_lp]])
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    issue_ready_o = 1'b0;
    r_v_o         = 1'b0;
    r_last_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        issue_ready_o = ~hazard;
        if (issue_v_i && !hazard && vl_nz) begin
          state_d = STREAM;
          beat_d  = '0;
        end
      end
      STREAM: begin
        r_v_o    = 1'b1;
        r_last_o = (beat_q == last_q);
        if (r_ready_i) begin
          if (r_last_o) state_d = IDLE;
          else          beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rs_q   <= '0;
      vl_q   <= '0;
      last_q <= '0;
    end else if (accept && vl_nz) begin
      rs_q   <= issue_rs_addr_i;
      vl_q   <= issue_vl_i;
      last_q <= bw_lp'((int'(issue_vl_i) - 1) / lanes_p);
    end
  end

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (w_v_i && w_last_i)
      busy_d[w_reg_addr_i] = 1'b0;
    if (accept && vl_nz && issue_wb_i)
      busy_d[issue_rd_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < els_p; r++)
        for (int b = 0; b < beats_lp; b++)
          for (int l = 0; l < lanes_p; l++)
            mem[r][b][l] <= '0;
    end else if (w_v_i) begin
      for (int l = 0; l < lanes_p; l++)
        if (w_mask_i[l])
          mem[w_reg_addr_i][w_beat_i][l] <= w_data_i[l*vdw_p +: vdw_p];
    end
  end

  always_comb begin
    r_mask_o = '0;
    for (int l = 0; l < lanes_p; l++)
      r_mask_o[l] = (int'(beat_q) * lanes_p + l) < int'(vl_q);
  end

  logic [aw_lp-1:0] rs_sel;

  always_comb begin
    r_data_o = '0;
    rs_sel   = '0;
    for (int p = 0; p < rports_p; p++) begin
      rs_sel = rs_q[p*aw_lp +: aw_lp];
      for (int l = 0; l < lanes_p; l++) begin
        r_data_o[(p*lanes_p+l)*vdw_p +: vdw_p] = mem[rs_sel][beat_q][l];
`ifdef VRF_WBYPASS_EN
        if (w_v_i && w_mask_i[l] &&
            w_reg_addr_i == rs_sel && w_beat_i == beat_q)
          r_data_o[(p*lanes_p+l)*vdw_p +: vdw_p] =
            w_data_i[l*vdw_p +: vdw_p];
`endif
      end
    end
  end

endmodule

// File: tb/tb_vrf_seq.sv
// Bench for vrf_seq: constant vector table, directed corner sequences,
// and randomized traffic against an element-indexed register file model.
`timescale 1ns/1ps
module tb_vrf_seq;

  localparam int ELS   = 32;
  localparam int VLEN  = 8;
  localparam int VDW   = 32;
  localparam int LANES = 4;
  localparam int RP    = 3;
  localparam int AW    = 5;
  localparam int VLW   = 4;
  localparam int BW    = 1;
  localparam int DW    = RP*LANES*VDW;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              issue_v_i;
  logic              issue_ready_o;
  logic [RP*AW-1:0]  issue_rs_addr_i;
  logic [RP-1:0]     issue_rs_en_i;
  logic [AW-1:0]     issue_rd_addr_i;
  logic              issue_wb_i;
  logic [VLW-1:0]    issue_vl_i;
  logic              r_v_o;
  logic              r_ready_i;
  logic [DW-1:0]     r_data_o;
  logic [LANES-1:0]  r_mask_o;
  logic              r_last_o;
  logic              w_v_i;
  logic [AW-1:0]     w_reg_addr_i;
  logic [BW-1:0]     w_beat_i;
  logic [LANES*VDW-1:0] w_data_i;
  logic [LANES-1:0]  w_mask_i;
  logic              w_last_i;
  logic [ELS-1:0]    busy_o;

  vrf_seq dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .issue_v_i(issue_v_i), .issue_ready_o(issue_ready_o),
    .issue_rs_addr_i(issue_rs_addr_i), .issue_rs_en_i(issue_rs_en_i),
    .issue_rd_addr_i(issue_rd_addr_i), .issue_wb_i(issue_wb_i),
    .issue_vl_i(issue_vl_i),
    .r_v_o(r_v_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_mask_o(r_mask_o), .r_last_o(r_last_o),
    .w_v_i(w_v_i), .w_reg_addr_i(w_reg_addr_i), .w_beat_i(w_beat_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i), .w_last_i(w_last_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [VDW-1:0] m_mem [ELS][VLEN];
  logic [ELS-1:0] m_busy;
  bit             m_act;
  int             m_beat;
  int             m_vl;
  int             m_rs [RP];

  bit g_acc, g_hs, g_last;
  int g_beats;
  logic [LANES-1:0] g_lmask;

  typedef struct {
    int vl; bit wb; int rd; int beats; logic [LANES-1:0] lmask;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ELS; r++)
      for (int e = 0; e < VLEN; e++) m_mem[r][e] = '0;
    m_busy = '0; m_act = 0; m_beat = 0; m_vl = 0;
    for (int p = 0; p < RP; p++) m_rs[p] = 0;
  endtask

  task automatic check_now();
    logic [DW-1:0]    ed;
    logic [LANES-1:0] em;
    logic [VDW-1:0]   v;
    logic             el, er;
    int               e;
    er = !m_act;
    for (int p = 0; p < RP; p++)
      if (issue_rs_en_i[p] && m_busy[issue_rs_addr_i[p*AW +: AW]]) er = 0;
    if (issue_wb_i && m_busy[issue_rd_addr_i]) er = 0;
    chk("issue_ready", issue_ready_o, er);
    chk("r_v", r_v_o, m_act);
    chk("busy", busy_o, m_busy);
    ed = '0; em = '0; el = 0;
    if (m_act) begin
      el = ((m_beat + 1) * LANES >= m_vl);
      for (int l = 0; l < LANES; l++) em[l] = (m_beat*LANES + l < m_vl);
      for (int p = 0; p < RP; p++)
        for (int l = 0; l < LANES; l++) begin
          e = m_beat*LANES + l;
          v = m_mem[m_rs[p]][e];
`ifdef VRF_WBYPASS_EN
          if (w_v_i && w_mask_i[l] && int'(w_reg_addr_i) == m_rs[p] &&
              int'(w_beat_i) == m_beat)
            v = w_data_i[l*VDW +: VDW];
`endif
          ed[(p*LANES+l)*VDW +: VDW] = v;
        end
      chk("r_mask", r_mask_o, em);
      chk("r_data", r_data_o, ed);
    end
    chk("r_last", r_last_o, el);
    if (r_v_o && r_ready_i) begin
      g_beats++;
      if (r_last_o) g_lmask = r_mask_o;
    end
    g_acc  = issue_v_i && er;
    g_hs   = m_act && r_ready_i;
    g_last = el;
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (w_v_i)
      for (int l = 0; l < LANES; l++)
        if (w_mask_i[l])
          m_mem[w_reg_addr_i][int'(w_beat_i)*LANES + l] = w_data_i[l*VDW +: VDW];
    if (w_v_i && w_last_i) m_busy[w_reg_addr_i] = 1'b0;
    if (g_hs) begin
      if (g_last) m_act = 0;
      else        m_beat++;
    end
    if (g_acc && issue_vl_i != 0) begin
      m_act = 1; m_beat = 0; m_vl = int'(issue_vl_i);
      for (int p = 0; p < RP; p++) m_rs[p] = int'(issue_rs_addr_i[p*AW +: AW]);
      if (issue_wb_i) m_busy[issue_rd_addr_i] = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk_i);
    check_now();
    advance();
  endtask

  task automatic idle_inputs();
    issue_v_i = 0; issue_rs_addr_i = '0; issue_rs_en_i = '0;
    issue_rd_addr_i = '0; issue_wb_i = 0; issue_vl_i = '0;
    r_ready_i = 1; w_v_i = 0; w_reg_addr_i = '0; w_beat_i = '0;
    w_data_i = '0; w_mask_i = '0; w_last_i = 0;
  endtask

  task automatic drain();
    issue_v_i = 0; r_ready_i = 1; w_v_i = 0;
    for (int i = 0; i < 20 && m_act; i++) step();
    chk("drain_done", m_act, 0);
  endtask

  task automatic issue(int rs0, logic [RP-1:0] en, int rd, bit wb, int vl);
    issue_v_i = 1;
    issue_rs_addr_i = '0;
    issue_rs_addr_i[AW-1:0] = AW'(rs0);
    issue_rs_en_i = en; issue_rd_addr_i = AW'(rd);
    issue_wb_i = wb; issue_vl_i = VLW'(vl);
  endtask

  task automatic wr(int rg, int bt, logic [VDW-1:0] d0, logic [VDW-1:0] d1,
                    logic [VDW-1:0] d2, logic [VDW-1:0] d3);
    w_v_i = 1; w_reg_addr_i = AW'(rg); w_beat_i = BW'(bt);
    w_data_i = {d3, d2, d1, d0}; w_mask_i = '1; w_last_i = 0;
    step();
    w_v_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [VDW-1:0] exp_l2;
    tbl[0] = '{8, 0, 0, 2, 4'b1111};
    tbl[1] = '{6, 0, 0, 2, 4'b0011};
    tbl[2] = '{0, 1, 9, 0, 4'b0000};
    tbl[3] = '{4, 0, 0, 1, 4'b1111};
    tbl[4] = '{1, 0, 0, 1, 4'b0001};
    tbl[5] = '{5, 0, 0, 2, 4'b0001};
    tbl[6] = '{7, 0, 0, 2, 4'b0111};

    idle_inputs();
    model_reset();
    reset_n_i = 0;
    #23;
    chk("rst_busy", busy_o, 0);
    chk("rst_r_v", r_v_o, 0);
    chk("rst_r_last", r_last_o, 0);
    chk("rst_ready", issue_ready_o, 1);
    @(posedge clk_i); #1;
    reset_n_i = 1;
    step();

    wr(5, 0, 1, 2, 3, 4);
    wr(5, 1, 5, 6, 7, 8);

    for (int i = 0; i < 7; i++) begin
      g_beats = 0; g_lmask = 'x;
      issue(5, 3'b001, tbl[i].rd, tbl[i].wb, tbl[i].vl);
      step();
      issue_v_i = 0;
      for (int k = 0; k < 20 && m_act; k++) step();
      chk("tbl_done", m_act, 0);
      chk("tbl_beats", g_beats, tbl[i].beats);
      if (tbl[i].beats > 0) chk("tbl_lmask", g_lmask, tbl[i].lmask);
      else chk("tbl_vl0_busy", busy_o[9], 0);
    end

    issue(5, 3'b001, 0, 0, 8);
    step();
    issue_v_i = 0;
    step();
    r_ready_i = 0;
    cyc = 1;
    repeat (3) begin step(); cyc++; end
    r_ready_i = 1;
    for (int k = 0; k < 10 && m_act; k++) begin step(); cyc++; end
    chk("bp_cycles", cyc, 5);

    issue(0, 3'b000, 3, 1, 8);
    step();
    issue_v_i = 0;
    @(negedge clk_i);
    chk("hz_busy3", busy_o[3], 1);
    check_now(); advance();
    drain();
    issue(3, 3'b001, 0, 0, 4);
    repeat (3) begin
      @(negedge clk_i);
      chk("hz_stall", issue_ready_o, 0);
      check_now(); advance();
    end
    w_v_i = 1; w_reg_addr_i = 3; w_mask_i = '0; w_last_i = 1;
    @(negedge clk_i);
    chk("hz_clr_cycle", issue_ready_o, 0);
    check_now(); advance();
    w_v_i = 0; w_last_i = 0;
    @(negedge clk_i);
    chk("hz_accept", issue_ready_o, 1);
    check_now(); advance();
    drain();

`ifdef VRF_WBYPASS_EN
    exp_l2 = 32'hDEAD;
`else
    exp_l2 = 32'd3;
`endif
    issue(5, 3'b001, 0, 0, 8);
    step();
    issue_v_i = 0;
    w_v_i = 1; w_reg_addr_i = 5; w_beat_i = 0;
    w_data_i = '0; w_data_i[2*VDW +: VDW] = 32'hDEAD;
    w_mask_i = 4'b0100; w_last_i = 0;
    @(negedge clk_i);
    chk("byp_lane0", r_data_o[VDW-1:0], 1);
    chk("byp_lane2", r_data_o[2*VDW +: VDW], exp_l2);
    check_now(); advance();
    w_v_i = 0;
    drain();

    for (int i = 0; i < 400; i++) begin
      issue_v_i = ($urandom_range(0, 1) == 1);
      for (int p = 0; p < RP; p++)
        issue_rs_addr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
      issue_rs_en_i   = RP'($urandom);
      issue_rd_addr_i = AW'($urandom_range(0, 7));
      issue_wb_i      = ($urandom_range(0, 1) == 1);
      issue_vl_i      = VLW'($urandom_range(0, VLEN));
      r_ready_i       = ($urandom_range(0, 3) != 0);
      w_v_i           = ($urandom_range(0, 1) == 1);
      w_reg_addr_i    = AW'($urandom_range(0, 7));
      w_beat_i        = BW'($urandom_range(0, 1));
      w_data_i        = {$urandom, $urandom, $urandom, $urandom};
      w_mask_i        = LANES'($urandom);
      w_last_i        = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();

    idle_inputs();
    issue(20, 3'b001, 21, 1, 8);
    step();
    issue_v_i = 0; r_ready_i = 0;
    step();
    reset_n_i = 0;
    #1;
    chk("mid_rst_r_v", r_v_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_last", r_last_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1; r_ready_i = 1;
    step();
    issue(5, 3'b001, 0, 0, 8);
    step();
    issue_v_i = 0;
    @(negedge clk_i);
    chk("mid_rst_mem", r_data_o[LANES*VDW-1:0], 0);
    check_now(); advance();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
